// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_pkg
// Description : Shared UART constants and the RAM dumper state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

    localparam int UART_FRAME_BITS      = 10;
    localparam int DEFAULT_CLKS_PER_BIT = 868;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_LOAD  = 3'd2,
        ST_SEND  = 3'd3,
        ST_NEXT  = 3'd4,
        ST_FIN   = 3'd5
    } dumper_state_t;

endpackage
`default_nettype wire

// File: rtl/uart_tx_byte.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_byte
// Description : Single-byte 8N1 serializer; tx_done marks the last stop cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_byte
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tx_start,
    input  logic [7:0] tx_data,
    output logic       tx_busy,
    output logic       tx_done,
    output logic       Tx_Serial
);

    localparam int                 c_cnt_w       = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [c_cnt_w-1:0] c_last_clk    = c_cnt_w'(CLKS_PER_BIT - 1);
    localparam logic [c_cnt_w-1:0] c_prelast_clk = c_cnt_w'(CLKS_PER_BIT - 2);
    localparam logic [c_cnt_w-1:0] c_clk_one     = c_cnt_w'(1);
    localparam logic [3:0]         c_stop_bit    = 4'(UART_FRAME_BITS - 1);

    logic               r_busy;
    logic               r_done;
    logic               r_tx;
    logic [8:0]         r_shift;
    logic [c_cnt_w-1:0] r_clk_cnt;
    logic [3:0]         r_bit_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_tx      <= 1'b1;
            r_shift   <= '0;
            r_clk_cnt <= '0;
            r_bit_cnt <= '0;
        end else begin
            r_done <= 1'b0;
            if (!r_busy) begin
                if (tx_start) begin
                    r_busy    <= 1'b1;
                    r_tx      <= 1'b0;
                    r_shift   <= {1'b1, tx_data};
                    r_clk_cnt <= '0;
                    r_bit_cnt <= '0;
                end
            end else if (r_clk_cnt == c_last_clk) begin
                r_clk_cnt <= '0;
                if (r_bit_cnt == c_stop_bit) begin
                    r_busy <= 1'b0;
                end else begin
                    // shift register refills with 1s so the stop bit falls out last
                    r_bit_cnt <= r_bit_cnt + 4'd1;
                    r_tx      <= r_shift[0];
                    r_shift   <= {1'b1, r_shift[8:1]};
                end
            end else begin
                r_clk_cnt <= r_clk_cnt + c_clk_one;
                r_done    <= (r_bit_cnt == c_stop_bit) && (r_clk_cnt == c_prelast_clk);
            end
        end
    end

    assign tx_busy   = r_busy;
    assign tx_done   = r_done;
    assign Tx_Serial = r_tx;

endmodule
`default_nettype wire

// File: rtl/uart_ram_dumper.sv
`default_nettype none
// ============================================================================
// Module      : uart_ram_dumper
// Description : Reads a block of 32-bit RAM words and sends them LSB-byte first over UART.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_ram_dumper
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int ADDR_W       = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   word_count,
    output logic              ram_rd_en,
    output logic [ADDR_W-1:0] ram_addr,
    input  logic [31:0]       ram_rdata,
    output logic              busy,
    output logic              done,
    output logic              Tx_Serial
);

    localparam logic [ADDR_W-1:0] c_ptr_one = ADDR_W'(1);
    localparam logic [ADDR_W:0]   c_rem_one = (ADDR_W + 1)'(1);

    dumper_state_t     r_state;
    logic [ADDR_W-1:0] r_ptr;
    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W:0]   r_rem;
    logic [31:0]       r_buf;
    logic [1:0]        r_byte_idx;
    logic              r_busy;
    logic              r_done;
    logic              r_rd_en;

    logic              w_tx_start;
    logic [7:0]        w_tx_data;
    logic              w_tx_busy;
    logic              w_tx_done;

    // Byte 0 goes straight from the RAM port in LOAD so the inter-word gap stays at three cycles.
    always_comb begin
        w_tx_start = 1'b0;
        w_tx_data  = r_buf[{r_byte_idx, 3'b000} +: 8];
        if (r_state == ST_LOAD) begin
            w_tx_start = 1'b1;
            w_tx_data  = ram_rdata[7:0];
        end else if (r_state == ST_SEND && !w_tx_busy) begin
            w_tx_start = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_ptr      <= '0;
            r_addr     <= '0;
            r_rem      <= '0;
            r_buf      <= '0;
            r_byte_idx <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_rd_en    <= 1'b0;
        end else begin
            r_done  <= 1'b0;
            r_rd_en <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_busy <= 1'b1;
                        if (word_count != '0) begin
                            r_ptr   <= base_addr;
                            r_rem   <= word_count;
                            r_addr  <= base_addr;
                            r_rd_en <= 1'b1;
                            r_state <= ST_FETCH;
                        end else begin
                            r_done  <= 1'b1;
                            r_state <= ST_FIN;
                        end
                    end
                end
                ST_FETCH: r_state <= ST_LOAD;
                ST_LOAD: begin
                    r_buf      <= ram_rdata;
                    r_byte_idx <= '0;
                    r_state    <= ST_SEND;
                end
                ST_SEND: begin
                    if (w_tx_done) begin
                        if (r_byte_idx == 2'd3) r_state <= ST_NEXT;
                        else                    r_byte_idx <= r_byte_idx + 2'd1;
                    end
                end
                ST_NEXT: begin
                    r_ptr <= r_ptr + c_ptr_one;
                    r_rem <= r_rem - c_rem_one;
                    if (r_rem == c_rem_one) begin
                        r_done  <= 1'b1;
                        r_state <= ST_FIN;
                    end else begin
                        r_addr  <= r_ptr + c_ptr_one;
                        r_rd_en <= 1'b1;
                        r_state <= ST_FETCH;
                    end
                end
                ST_FIN: begin
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    uart_tx_byte #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_tx (
        .clk       (clk),
        .reset     (reset),
        .tx_start  (w_tx_start),
        .tx_data   (w_tx_data),
        .tx_busy   (w_tx_busy),
        .tx_done   (w_tx_done),
        .Tx_Serial (Tx_Serial)
    );

    assign ram_rd_en = r_rd_en;
    assign ram_addr  = r_addr;
    assign busy      = r_busy;
    assign done      = r_done;

endmodule
`default_nettype wire

// File: tb/tb_uart_ram_dumper.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_ram_dumper
// Description : Directed bench for uart_ram_dumper; decodes the serial line from a per-cycle trace.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_ram_dumper;

    localparam int CPB   = 4;
    localparam int AW    = 10;
    localparam int FRAME = 10 * CPB;
    localparam int MAXC  = 8192;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [AW-1:0] base_addr;
    logic [AW:0]   word_count;
    logic          ram_rd_en;
    logic [AW-1:0] ram_addr;
    logic [31:0]   ram_rdata = '0;
    logic          busy;
    logic          done;
    logic          Tx_Serial;

    always #5 clk = ~clk;

    uart_ram_dumper #(
        .CLKS_PER_BIT(CPB),
        .ADDR_W      (AW)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .base_addr  (base_addr),
        .word_count (word_count),
        .ram_rd_en  (ram_rd_en),
        .ram_addr   (ram_addr),
        .ram_rdata  (ram_rdata),
        .busy       (busy),
        .done       (done),
        .Tx_Serial  (Tx_Serial)
    );

    // RAM with one-cycle read latency
    logic [31:0] mem [0:(1<<AW)-1];
    always @(posedge clk) if (ram_rd_en) ram_rdata <= mem[ram_addr];

    // per-cycle trace, sampled mid-cycle
    int            gcyc = 0;
    logic          tr_tx    [MAXC];
    logic          tr_rd    [MAXC];
    logic          tr_done  [MAXC];
    logic          tr_busy  [MAXC];
    logic          tr_start [MAXC];
    logic [AW-1:0] tr_addr  [MAXC];

    always @(negedge clk) begin
        if (gcyc < MAXC) begin
            tr_tx[gcyc]    = Tx_Serial;
            tr_rd[gcyc]    = ram_rd_en;
            tr_done[gcyc]  = done;
            tr_busy[gcyc]  = busy;
            tr_start[gcyc] = start;
            tr_addr[gcyc]  = ram_addr;
        end
        gcyc = gcyc + 1;
    end

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
        end
    endtask

    typedef struct packed {
        logic [AW-1:0] base;
        logic [AW:0]   cnt;
        logic [7:0]    nbytes;
        logic [95:0]   bytes;    // byte 0 of the stream in [7:0]
        logic [29:0]   addrs;    // read 0 in [9:0]
        logic [15:0]   restart;  // cycles after start to pulse start again (0 = never)
    } vec_t;

    vec_t vecs [6];

    task automatic run_vec(input int vi, input vec_t v);
        int t0, t1, s, nrd, nby, werr, ndone, didx, ones, exp_done, gap, fidx[12];
        logic [7:0] byt [12];
        logic [7:0] d;
        logic bv;
        bit got;

        @(posedge clk); #1;
        t0 = gcyc;
        base_addr = v.base; word_count = v.cnt; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        if (v.restart != 0) begin
            repeat (int'(v.restart) - 1) @(posedge clk);
            #1;
            base_addr = 10'h010; word_count = 11'd3; start = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
        end
        got = 1'b0;
        for (int w = 0; w < 3000 && !got; w++) begin
            @(negedge clk);
            if (done) got = 1'b1;
        end
        check($sformatf("v%0d done seen", vi), 32'(got), 32'd1);
        repeat (3) @(posedge clk);
        #1;
        t1 = gcyc;

        s = -1;
        for (int i = t0; i < t1; i++) if (tr_start[i] && s < 0) s = i;
        check($sformatf("v%0d busy before accept", vi), 32'(tr_busy[s]), 32'd0);
        check($sformatf("v%0d busy after accept", vi), 32'(tr_busy[s+1]), 32'd1);

        nrd = 0;
        for (int i = t0; i < t1; i++) begin
            if (tr_rd[i]) begin
                if (nrd < 3) check($sformatf("v%0d read%0d addr", vi, nrd), 32'(tr_addr[i]), 32'(v.addrs[nrd*10 +: 10]));
                if (nrd == 0) check($sformatf("v%0d first read cycle", vi), i - s, 32'd1);
                nrd++;
            end
        end
        check($sformatf("v%0d read count", vi), nrd, 32'(v.cnt));

        nby = 0; werr = 0; ones = 0;
        for (int i = t0; i < t1; i++) if (tr_tx[i]) ones++;
        for (int i = t0 + 1; i < t1; ) begin
            if (tr_tx[i] == 1'b0 && tr_tx[i-1] == 1'b1) begin
                if (i + FRAME > t1) begin werr++; break; end
                for (int k = 0; k < CPB; k++) if (tr_tx[i+k] !== 1'b0) werr++;
                for (int b = 0; b < 8; b++) begin
                    bv = tr_tx[i+CPB+CPB*b];
                    for (int k = 1; k < CPB; k++) if (tr_tx[i+CPB+CPB*b+k] !== bv) werr++;
                    d[b] = bv;
                end
                for (int k = 0; k < CPB; k++) if (tr_tx[i+9*CPB+k] !== 1'b1) werr++;
                if (nby < 12) begin byt[nby] = d; fidx[nby] = i; end
                nby++;
                i += FRAME;
            end else begin
                i++;
            end
        end
        check($sformatf("v%0d bit width errors", vi), werr, 32'd0);
        check($sformatf("v%0d byte count", vi), nby, 32'(v.nbytes));
        if (v.cnt == 0) check($sformatf("v%0d line idle", vi), ones, t1 - t0);
        for (int j = 0; j < nby && j < 12 && j < int'(v.nbytes); j++)
            check($sformatf("v%0d byte%0d", vi, j), 32'(byt[j]), 32'(v.bytes[j*8 +: 8]));
        if (nby > 0) check($sformatf("v%0d first start bit", vi), fidx[0] - s, 32'd3);
        for (int j = 1; j < nby && j < 12; j++) begin
            gap = fidx[j] - (fidx[j-1] + FRAME);
            check($sformatf("v%0d gap before byte%0d", vi, j), gap, (j % 4 == 0) ? 32'd3 : 32'd1);
        end

        ndone = 0; didx = -1;
        for (int i = t0; i < t1; i++) if (tr_done[i]) begin ndone++; if (didx < 0) didx = i; end
        exp_done = (v.cnt == 0) ? s + 1 : s + 3 + (4 * FRAME + 6) * int'(v.cnt) - 2;
        check($sformatf("v%0d done pulses", vi), ndone, 32'd1);
        check($sformatf("v%0d done cycle", vi), didx - s, exp_done - s);
        if (didx >= 0 && didx + 1 < t1) begin
            check($sformatf("v%0d busy at done", vi), 32'(tr_busy[didx]), 32'd1);
            check($sformatf("v%0d busy after done", vi), 32'(tr_busy[didx+1]), 32'd0);
        end
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; base_addr = '0; word_count = '0;
        for (int i = 0; i < (1 << AW); i++) mem[i] = 32'h0;
        mem[10'h005] = 32'h12345678;
        mem[10'h010] = 32'hA5A5A5A5;
        mem[10'h011] = 32'h00000000;
        mem[10'h012] = 32'hFFFFFFFF;
        mem[10'h3FF] = 32'hDEADBEEF;
        mem[10'h000] = 32'h0BADF00D;
        mem[10'h040] = 32'h55555555;

        vecs[0] = '{base: 10'h005, cnt: 11'd1, nbytes: 8'd4,  bytes: 96'h12345678,
                    addrs: 30'h005, restart: 16'd0};
        vecs[1] = '{base: 10'h010, cnt: 11'd3, nbytes: 8'd12, bytes: 96'hFFFFFFFF_00000000_A5A5A5A5,
                    addrs: {10'h012, 10'h011, 10'h010}, restart: 16'd0};
        vecs[2] = '{base: 10'h3FF, cnt: 11'd2, nbytes: 8'd8,  bytes: 96'h0BADF00D_DEADBEEF,
                    addrs: {10'h000, 10'h000, 10'h3FF}, restart: 16'd0};
        vecs[3] = '{base: 10'h020, cnt: 11'd0, nbytes: 8'd0,  bytes: 96'h0,
                    addrs: 30'h0, restart: 16'd0};
        vecs[4] = '{base: 10'h005, cnt: 11'd1, nbytes: 8'd4,  bytes: 96'h12345678,
                    addrs: 30'h005, restart: 16'd90};
        vecs[5] = '{base: 10'h040, cnt: 11'd1, nbytes: 8'd4,  bytes: 96'h55555555,
                    addrs: 30'h040, restart: 16'd0};

        repeat (3) @(negedge clk);
        check("reset tx", 32'(Tx_Serial), 32'd1);
        check("reset busy", 32'(busy), 32'd0);
        check("reset done", 32'(done), 32'd0);
        check("reset rd_en", 32'(ram_rd_en), 32'd0);
        check("reset addr", 32'(ram_addr), 32'd0);
        reset = 1'b0;

        for (int vi = 0; vi < 5; vi++) run_vec(vi, vecs[vi]);

        // abort a dump during data bit 1 of byte 0x78 (a 0 on the line)
        @(posedge clk); #1;
        base_addr = 10'h005; word_count = 11'd1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #3;
        check("abort pre busy", 32'(busy), 32'd1);
        check("abort pre tx", 32'(Tx_Serial), 32'd0);
        reset = 1'b1;
        #1;
        check("abort tx", 32'(Tx_Serial), 32'd1);
        check("abort busy", 32'(busy), 32'd0);
        check("abort rd_en", 32'(ram_rd_en), 32'd0);
        check("abort done", 32'(done), 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;

        run_vec(5, vecs[5]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
